ps2_mouse_packet_decoder: RTL

//  Consumes the byte stream from the PS/2 receive stage (one rx_complete-style pulse per byte) after

---
 rtl/ps2_mouse_packet_decoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse packet decoder: frames 3-byte streaming-mode packets, decodes
// buttons, deltas and overflow flags, and tracks a saturating cursor position.
module ps2_mouse_packet_decoder #(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int POS_W       = 10,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    input  logic             clear,
    output logic             packet_valid,
    output logic             btn_left,
    output logic             btn_right,
    output logic             btn_middle,
    output logic [8:0]       dx,
    output logic [8:0]       dy,
    output logic             x_ovf,
    output logic             y_ovf,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             sync_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [POS_W-1:0] X_CTR  = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0] Y_CTR  = POS_W'(Y_MAX / 2);
    localparam logic signed [POS_W+1:0] X_LIM = (POS_W + 2)'(X_MAX);
    localparam logic signed [POS_W+1:0] Y_LIM = (POS_W + 2)'(Y_MAX);

    typedef enum logic [1:0] {
        WAIT_B1 = 2'd0,
        WAIT_B2 = 2'd1,
        WAIT_B3 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       b1_q, b2_q;

    logic take_b1, take_b2, finish, drop, timeout;

    logic [8:0]               dx_new, dy_new;
    logic signed [POS_W+1:0]  x_sum, y_sum;
    logic [POS_W-1:0]         x_clamp, y_clamp;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_B1;
        else        state_q <= state_d;
    end

    // Framing: next state and byte-consume decisions. A timeout returns to
    // byte1 hunting in the same cycle, so a coincident byte is a byte1 candidate.
    always_comb begin
        state_d = state_q;
        take_b1 = 1'b0;
        take_b2 = 1'b0;
        finish  = 1'b0;
        drop    = 1'b0;
        timeout = (state_q != WAIT_B1) && (cnt_q == TO_VAL);
        if (state_q == WAIT_B1 || timeout) begin
            state_d = WAIT_B1;
            if (byte_valid) begin
                if (byte_in[3]) begin
                    take_b1 = 1'b1;
                    state_d = WAIT_B2;
                end else begin
                    drop = 1'b1;
                end
            end
        end else if (byte_valid) begin
            if (state_q == WAIT_B2) begin
                take_b2 = 1'b1;
                state_d = WAIT_B3;
            end else begin
                finish  = 1'b1;
                state_d = WAIT_B1;
            end
        end
    end

    // Inter-byte idle counter, active only while a packet is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     cnt_q <= '0;
        else if (take_b1 || take_b2 || finish || timeout) cnt_q <= '0;
        else if (state_q != WAIT_B1)                    cnt_q <= cnt_q + 1'b1;
        else                                            cnt_q <= '0;
    end

    // Partial packet byte storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1_q <= '0;
            b2_q <= '0;
        end else begin
            if (take_b1) b1_q <= byte_in;
            if (take_b2) b2_q <= byte_in;
        end
    end

    // Decoded deltas and saturated position candidates for the completing packet.
    always_comb begin
        dx_new = {b1_q[4], b2_q};
        dy_new = {b1_q[5], byte_in};
        x_sum  = $signed({2'b00, x_pos}) + $signed({{(POS_W-7){dx_new[8]}}, dx_new});
        y_sum  = $signed({2'b00, y_pos}) - $signed({{(POS_W-7){dy_new[8]}}, dy_new});
        if (x_sum < 0)          x_clamp = '0;
        else if (x_sum > X_LIM) x_clamp = X_CTR + X_CTR + POS_W'(X_MAX % 2);
        else                    x_clamp = x_sum[POS_W-1:0];
        if (y_sum < 0)          y_clamp = '0;
        else if (y_sum > Y_LIM) y_clamp = Y_CTR + Y_CTR + POS_W'(Y_MAX % 2);
        else                    y_clamp = y_sum[POS_W-1:0];
    end

    // Output registers: strobes, decoded fields and cursor position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            packet_valid <= 1'b0;
            sync_err     <= 1'b0;
            btn_left     <= 1'b0;
            btn_right    <= 1'b0;
            btn_middle   <= 1'b0;
            dx           <= '0;
            dy           <= '0;
            x_ovf        <= 1'b0;
            y_ovf        <= 1'b0;
            x_pos        <= X_CTR;
            y_pos        <= Y_CTR;
        end else begin
            packet_valid <= finish;
            sync_err     <= drop | timeout;
            if (finish) begin
                btn_left   <= b1_q[0];
                btn_right  <= b1_q[1];
                btn_middle <= b1_q[2];
                dx         <= dx_new;
                dy         <= dy_new;
                x_ovf      <= b1_q[6];
                y_ovf      <= b1_q[7];
            end
            if (clear) begin
                x_pos <= X_CTR;
                y_pos <= Y_CTR;
            end else if (finish) begin
                if (!b1_q[6]) x_pos <= x_clamp;
                if (!b1_q[7]) y_pos <= y_clamp;
            end
        end
    end

endmodule
